alu: RTL and testbench

Registered 32-bit integer ALU for the execute stage of the 5-stage RISC-V pipeline. It computes one of the RV32I arithmetic, logic, compare or shift results from two operands and a 4-bit control code supplied by the ALU decoder. The result and a zero flag are registered on the rising clock edge.

---
 rtl/alu.sv | 67 ++++++
 tb/tb_alu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit RV32I execute-stage ALU: one operation per cycle, result and zero flag registered.
// Optional macro ALU_SHIFT_EN adds SLL/SRL/SRA; without it those codes return 0 like any unlisted code.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_out,
    output logic        zero
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_XOR  = 4'b1100,
        ALU_NOR  = 4'b1101
    } alu_op_e;

    logic [31:0] result_next;

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = operand2[4:0];
`endif

    // NOTE: result_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result_next = '0;
        case (alu_control)
            ALU_AND:  result_next = operand1 & operand2;
            ALU_OR:   result_next = operand1 | operand2;
            ALU_ADD:  result_next = operand1 + operand2;
            ALU_SUB:  result_next = operand1 - operand2;
            ALU_SLT:  result_next = {31'd0, $signed(operand1) < $signed(operand2)};
            ALU_SLTU: result_next = {31'd0, operand1 < operand2};
            ALU_XOR:  result_next = operand1 ^ operand2;
            ALU_NOR:  result_next = ~(operand1 | operand2);
`ifdef ALU_SHIFT_EN
            ALU_SLL:  result_next = operand1 << shamt;
            ALU_SRL:  result_next = operand1 >> shamt;
            ALU_SRA:  result_next = 32'($signed(operand1) >>> shamt);
`endif
            default:  result_next = '0;
        endcase
    end

    // zero is derived from result_next so both registers always agree with each other.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out <= '0;
            zero    <= 1'b1;
        end else begin
            alu_out <= result_next;
            zero    <= (result_next == 32'd0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; shift expectations follow ALU_SHIFT_EN.
module tb_alu;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NOR  = 4'b1101;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .operand1    (operand1),
        .operand2    (operand2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set inputs on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_control = op;
        operand1    = a;
        operand2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(OP_ADD, 32'd10, 32'd5);
            n_cmp++;
            if (alu_out !== 32'd0) begin
                n_err++;
                $display("FAIL reset_out[%0d]: got %h want %h", i, alu_out, 32'd0);
            end
            n_cmp++;
            if (zero !== 1'b1) begin
                n_err++;
                $display("FAIL reset_zero[%0d]: got %b want 1", i, zero);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (alu_out !== 32'd15) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", alu_out, 32'd15);
        end
        n_cmp++;
        if (zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_zero: got %b want 0", zero);
        end
    endtask

    task automatic test_arith();
        vec_t v[8];
        v[0] = '{OP_AND,  32'd10,        32'd5,         32'd0};
        v[1] = '{OP_OR,   32'd10,        32'd5,         32'd15};
        v[2] = '{OP_ADD,  32'd10,        32'd5,         32'd15};
        v[3] = '{OP_SUB,  32'd10,        32'd5,         32'd5};
        v[4] = '{OP_SLT,  32'd3,         32'd9,         32'd1};
        v[5] = '{OP_SLT,  32'hFFFFFFFF,  32'd1,         32'd1};
        v[6] = '{OP_SLTU, 32'hFFFFFFFF,  32'd1,         32'd0};
        v[7] = '{OP_SUB,  32'd5,         32'd10,        32'hFFFFFFFB};
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (alu_out !== v[i].exp) begin
                n_err++;
                $display("FAIL arith[%0d] op=%b: got %h want %h", i, v[i].op, alu_out, v[i].exp);
            end
            n_cmp++;
            if (zero !== (v[i].exp == 32'd0)) begin
                n_err++;
                $display("FAIL arith_zero[%0d]: got %b want %b", i, zero, v[i].exp == 32'd0);
            end
        end
    endtask

    task automatic test_logic_bounds();
        vec_t v[6];
        v[0] = '{OP_XOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF};
        v[1] = '{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000};
        v[2] = '{OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000};
        v[3] = '{OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'd1};
        v[4] = '{OP_SLTU, 32'h80000000, 32'h7FFFFFFF, 32'd0};
        v[5] = '{4'b1111, 32'd10,       32'd5,        32'd0};
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (alu_out !== v[i].exp) begin
                n_err++;
                $display("FAIL logic[%0d] op=%b: got %h want %h", i, v[i].op, alu_out, v[i].exp);
            end
            n_cmp++;
            if (zero !== (v[i].exp == 32'd0)) begin
                n_err++;
                $display("FAIL logic_zero[%0d]: got %b want %b", i, zero, v[i].exp == 32'd0);
            end
        end
        // Remaining unlisted codes, each preceded by an OR that leaves a nonzero output.
        for (int c = 9; c <= 14; c++) begin
            if (c == 12 || c == 13) continue;
            drive(OP_OR, 32'd10, 32'd5);
            drive(4'(c), 32'd10, 32'd5);
            n_cmp++;
            if (alu_out !== 32'd0 || zero !== 1'b1) begin
                n_err++;
                $display("FAIL unlisted code=%0d: got %h/%b want 0/1", c, alu_out, zero);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[5];
`ifdef ALU_SHIFT_EN
        v[0] = '{OP_SLL, 32'd1,        32'd31, 32'h80000000};
        v[1] = '{OP_SRA, 32'h80000000, 32'd4,  32'hF8000000};
        v[2] = '{OP_SRL, 32'h80000000, 32'd4,  32'h08000000};
        v[3] = '{OP_SLL, 32'd1,        32'd33, 32'd2};
        v[4] = '{OP_SLL, 32'd1,        32'd4,  32'd16};
`else
        v[0] = '{OP_SLL, 32'd1,        32'd31, 32'd0};
        v[1] = '{OP_SRA, 32'h80000000, 32'd4,  32'd0};
        v[2] = '{OP_SRL, 32'h80000000, 32'd4,  32'd0};
        v[3] = '{OP_SLL, 32'd1,        32'd33, 32'd0};
        v[4] = '{OP_SLL, 32'd1,        32'd4,  32'd0};
`endif
        foreach (v[i]) begin
            drive(OP_OR, 32'd10, 32'd5);
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (alu_out !== v[i].exp) begin
                n_err++;
                $display("FAIL shift[%0d] op=%b: got %h want %h", i, v[i].op, alu_out, v[i].exp);
            end
            n_cmp++;
            if (zero !== (v[i].exp == 32'd0)) begin
                n_err++;
                $display("FAIL shift_zero[%0d]: got %b want %b", i, zero, v[i].exp == 32'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 32'd10, 32'd5);
        // New inputs before the edge must not disturb the held result.
        @(negedge clk);
        alu_control = OP_AND;
        operand1    = 32'd10;
        operand2    = 32'd5;
        #2;
        n_cmp++;
        if (alu_out !== 32'd15) begin
            n_err++;
            $display("FAIL hold_before_edge: got %h want %h", alu_out, 32'd15);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (alu_out !== 32'd0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_and: got %h/%b want 0/1", alu_out, zero);
        end
        drive(OP_SUB, 32'd10, 32'd5);
        n_cmp++;
        if (alu_out !== 32'd5 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_sub: got %h/%b want 5/0", alu_out, zero);
        end
    endtask

    task automatic test_mid_reset();
        drive(OP_ADD, 32'd10, 32'd5);
        @(negedge clk);
        rst_n       = 1'b0;
        alu_control = OP_SUB;
        operand1    = 32'd10;
        operand2    = 32'd5;
        @(posedge clk);
        #1;
        n_cmp++;
        if (alu_out !== 32'd0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got %h/%b want 0/1", alu_out, zero);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        alu_control = OP_OR;
        @(posedge clk);
        #1;
        n_cmp++;
        if (alu_out !== 32'd15 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_release: got %h/%b want f/0", alu_out, zero);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        operand1    = '0;
        operand2    = '0;
        alu_control = '0;
        test_reset();
        test_arith();
        test_logic_bounds();
        test_shift();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
